// File: rtl/timer_pkg.sv
// Shared types and constants for the multi-channel countdown timer.
// Imported by the channel and the top level.
package timer_pkg;

    typedef enum logic [1:0] {
        TMR_IDLE = 2'd0,
        TMR_RUN  = 2'd1,
        TMR_DONE = 2'd2
    } tmr_state_t;

    localparam logic TMR_ONESHOT  = 1'b0;
    localparam logic TMR_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN/DONE FSM with down-counter and reload.
// Also exports its next-cycle expiry term so the top can register a combined flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             periodic,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expire,
    output logic             expire_nxt
);

    tmr_state_t       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;
    logic             busy_q, done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TMR_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= TMR_ONESHOT;
            expire_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
            busy_q   <= (state_d == TMR_RUN);
            done_q   <= (state_d == TMR_DONE);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = 1'b0;
        priority case (1'b1)
            start: begin
                state_d  = TMR_RUN;
                count_d  = load_val;
                reload_d = load_val;
                mode_d   = periodic;
            end
            stop: begin
                state_d = TMR_IDLE;
                count_d = '0;
            end
            default: begin
                // Hold only freezes a running channel; count 0 fires next.
                if (state_q == TMR_RUN && !hold) begin
                    if (count_q != '0) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        expire_d = 1'b1;
                        if (mode_q == TMR_PERIODIC) begin
                            count_d = reload_q;
                        end else begin
                            state_d = TMR_DONE;
                        end
                    end
                end
            end
        endcase
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign expire     = expire_q;
    assign expire_nxt = expire_d;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: CHANNELS independent timer_channel instances
// plus a registered OR of their expiry terms for an interrupt line.
module multi_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       hold,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expire,
    output logic                      any_expire
);

    logic [CHANNELS-1:0] expire_nxt;
    logic                any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .start     (start[i]),
            .stop      (stop[i]),
            .hold      (hold[i]),
            .periodic  (periodic[i]),
            .load_val  (load_val[i*WIDTH +: WIDTH]),
            .count     (count[i*WIDTH +: WIDTH]),
            .busy      (busy[i]),
            .done      (done[i]),
            .expire    (expire[i]),
            .expire_nxt(expire_nxt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |expire_nxt;
        end
    end

    assign any_expire = any_q;

endmodule
